// File: rtl/axi4_slave_pkg.sv
// ============================================================================
// Module : axi4_slave_pkg
// Brief  : Shared types for the AXI4 slave write path (FSM states, BRESP codes,
//          queued AW command layout).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi4_slave_pkg;

    // Field widths of a queued AW command; keep in step with the top-level
    // ID_WIDTH / ADDR_WIDTH / BURST_LENGTH parameters.
    localparam int CMD_ID_W   = 4;
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_LEN_W  = 8;

    typedef logic [1:0] resp_t;
    localparam resp_t OKAY   = 2'b00;
    localparam resp_t SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RESP = 2'd2
    } wsched_state_t;

    typedef struct packed {
        logic [CMD_ID_W-1:0]   id;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_LEN_W-1:0]  len;
    } aw_cmd_t;

endpackage

`default_nettype wire

// File: rtl/axi4_cmd_fifo.sv
// ============================================================================
// Module : axi4_cmd_fifo
// Brief  : Synchronous show-ahead FIFO for queued AW commands.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_cmd_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int              PTR_W  = $clog2(DEPTH);
    localparam logic [PTR_W:0]  C_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == C_FULL);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi4_slave_write_scheduler.sv
// ============================================================================
// Module : axi4_slave_write_scheduler
// Brief  : Queues AW commands and sequences W bursts in order onto the memory
//          write port, issuing one B response per burst.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_slave_write_scheduler
    import axi4_slave_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int BURST_LENGTH = 8,
    parameter int CMD_DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [BURST_LENGTH-1:0]   awlen,
    input  logic [ID_WIDTH-1:0]       awid,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wlast,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [ID_WIDTH-1:0]       bid,
    output logic [1:0]                bresp,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb
);

    localparam int C_BYTES = DATA_WIDTH / 8;

    wsched_state_t           r_state;
    logic [ID_WIDTH-1:0]     r_cur_id;
    logic [ADDR_WIDTH-1:0]   r_cur_addr;
    logic [BURST_LENGTH-1:0] r_beat_cnt;
    logic                    r_err;
    logic                    r_bvalid;
    logic [ID_WIDTH-1:0]     r_bid;
    resp_t                   r_bresp;

    aw_cmd_t                 w_push_cmd;
    aw_cmd_t                 w_pop_cmd;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_beat;
    logic                    w_final;
    logic                    w_err_next;

    assign w_push_cmd = '{id: awid, addr: awaddr, len: awlen};
    assign awready    = rst && !w_fifo_full;
    assign w_push     = awvalid && awready;
    assign w_pop      = (r_state == S_IDLE) && !w_fifo_empty;

    axi4_cmd_fifo #(
        .WIDTH ($bits(aw_cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_cmd),
        .dout  (w_pop_cmd),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign wready     = (r_state == S_DATA);
    assign w_beat     = wvalid && wready;
    assign w_final    = (r_beat_cnt == '0);
    // A protocol error is a wlast that disagrees with our own beat count.
    assign w_err_next = r_err | (w_final ? !wlast : wlast);

    assign mem_we     = w_beat;
    assign mem_addr   = r_cur_addr;
    assign mem_wdata  = wdata;
    assign mem_wstrb  = wstrb;

    assign bvalid     = r_bvalid;
    assign bid        = r_bid;
    assign bresp      = r_bresp;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cur_id   <= '0;
            r_cur_addr <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bid      <= '0;
            r_bresp    <= OKAY;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_cur_id   <= w_pop_cmd.id;
                        r_cur_addr <= w_pop_cmd.addr;
                        r_beat_cnt <= w_pop_cmd.len;
                        r_err      <= 1'b0;
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        r_cur_addr <= r_cur_addr + ADDR_WIDTH'(C_BYTES);
                        r_beat_cnt <= r_beat_cnt - 1'b1;
                        r_err      <= w_err_next;
                        if (w_final) begin
                            r_state  <= S_RESP;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_cur_id;
                            r_bresp  <= w_err_next ? SLVERR : OKAY;
                        end
                    end
                end
                S_RESP: begin
                    if (bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
